ram_lsu: RTL and testbench

- Load/store sequencer: initiator side of the byte-write / word-read data RAM.
- Accepts RISC-V style load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) from the core.
- Stores are serialized into one RAM byte write per cycle. Loads issue one RAM read and return the sign- or zero-extended result.
- Sits between the core's MEM stage and the data RAM.

---
 rtl/ram_lsu.sv | 182 ++++++++++++++++++
 tb/tb_ram_lsu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu.sv
// Load/store sequencer between the core MEM stage and a byte-write / word-read data RAM.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module ram_lsu #(
  parameter int ADDR_W    = 6,
  parameter int MEM_BYTES = 64
) (
  input  logic              LSU_clk,
  input  logic              LSU_rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_add,
  output logic [7:0]        RAM_in,
  input  logic [31:0]       RAM_out
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        size_q;
  logic [1:0]        last_k_q;
  logic [1:0]        k;
  logic              err_q;

  logic [1:0]        req_last;
  logic              code_ok;
  logic              bound_ok;
  logic              align_ok;
  logic              accept_ok;
  logic [31:0]       end_byte;

  // Index of the final byte for a size code: n-1 for n = 1/2/4.
  function automatic logic [1:0] last_index(input logic [1:0] sz);
    case (sz)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Request legality, evaluated on the live inputs while IDLE.
  always_comb begin
    req_last = last_index(funct3[1:0]);
    if (we) begin
      code_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      code_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end
    end_byte = 32'(addr) + 32'(req_last);
    bound_ok = (end_byte <= 32'(MEM_BYTES - 1));
`ifdef LSU_ALIGN_CHECK_EN
    align_ok = !(((req_last == 2'd1) && addr[0]) ||
                 ((req_last == 2'd3) && (addr[1:0] != 2'b00)));
`else
    align_ok = 1'b1;
`endif
    accept_ok = code_ok && bound_ok && align_ok;
  end

  always_ff @(posedge LSU_clk or negedge LSU_rst_n) begin
    if (!LSU_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    RAM_WE     = 1'b0;
    RAM_add    = addr_q;
    RAM_in     = 8'd0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (!accept_ok) begin
            state_next = DONE;
          end else if (we) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      WR: begin
        RAM_WE  = 1'b1;
        RAM_add = addr_q + ADDR_W'(k);
        case (k)
          2'd0:    RAM_in = wdata_q[7:0];
          2'd1:    RAM_in = wdata_q[15:8];
          2'd2:    RAM_in = wdata_q[23:16];
          default: RAM_in = wdata_q[31:24];
        endcase
        if (k == last_k_q) begin
          state_next = DONE;
        end
      end
      RD: begin
        state_next = CAP;
      end
      CAP: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        err        = err_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Rejected requests leave the latched address alone so RAM_add stays quiet.
  always_ff @(posedge LSU_clk or negedge LSU_rst_n) begin
    if (!LSU_rst_n) begin
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      size_q   <= 3'd0;
      last_k_q <= 2'd0;
      k        <= 2'd0;
      err_q    <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            err_q <= !accept_ok;
            k     <= 2'd0;
            if (accept_ok) begin
              addr_q   <= addr;
              wdata_q  <= wdata;
              size_q   <= funct3;
              last_k_q <= req_last;
            end
          end
        end
        WR: begin
          k <= k + 2'd1;
        end
        CAP: begin
          rdata <= extend_load(size_q, RAM_out);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu with a byte-write / word-read RAM model.
// Expected values are hand-computed; LSU_ALIGN_CHECK_EN selects the misaligned-store expectation.
module tb_ram_lsu;

  logic        LSU_clk;
  logic        LSU_rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        RAM_WE;
  logic [5:0]  RAM_add;
  logic [7:0]  RAM_in;
  logic [31:0] RAM_out;

  logic [7:0]  mem [64];

  int checks = 0;
  int errors = 0;

  ram_lsu #(.ADDR_W(6), .MEM_BYTES(64)) dut (
    .LSU_clk(LSU_clk),
    .LSU_rst_n(LSU_rst_n),
    .req(req),
    .we(we),
    .funct3(funct3),
    .addr(addr),
    .wdata(wdata),
    .ready(ready),
    .done(done),
    .err(err),
    .rdata(rdata),
    .RAM_WE(RAM_WE),
    .RAM_add(RAM_add),
    .RAM_in(RAM_in),
    .RAM_out(RAM_out)
  );

  initial begin
    LSU_clk = 1'b0;
    forever #5 LSU_clk = ~LSU_clk;
  end

  // RAM model: byte write, registered little-endian word read starting at RAM_add.
  always @(posedge LSU_clk) begin
    if (RAM_WE) mem[RAM_add] <= RAM_in;
    RAM_out <= {mem[RAM_add + 6'd3], mem[RAM_add + 6'd2], mem[RAM_add + 6'd1], mem[RAM_add]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] f, input logic [5:0] a,
                               input logic [31:0] d);
    checkOutput("ready_before_req", 32'(ready), 32'd1);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge LSU_clk); #1;
    req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 6'd0; wdata = 32'd0;
  endtask

  task automatic doStore(input string tag, input logic [2:0] f, input logic [5:0] a,
                         input logic [31:0] d, input int n);
    logic [5:0] ea;
    applyStimulus(1'b1, f, a, d);
    for (int i = 0; i < n; i++) begin
      ea = a + 6'(i);
      checkOutput($sformatf("%s_we%0d", tag, i), 32'(RAM_WE), 32'd1);
      checkOutput($sformatf("%s_add%0d", tag, i), 32'(RAM_add), 32'(ea));
      checkOutput($sformatf("%s_in%0d", tag, i), 32'(RAM_in), (d >> (8 * i)) & 32'hFF);
      checkOutput($sformatf("%s_nodone%0d", tag, i), 32'(done), 32'd0);
      @(posedge LSU_clk); #1;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_we_off"}, 32'(RAM_WE), 32'd0);
    @(posedge LSU_clk); #1;
  endtask

  task automatic doLoad(input string tag, input logic [2:0] f, input logic [5:0] a,
                        input logic [31:0] exp);
    applyStimulus(1'b0, f, a, 32'd0);
    checkOutput({tag, "_rd_we"}, 32'(RAM_WE), 32'd0);
    checkOutput({tag, "_rd_add"}, 32'(RAM_add), 32'(a));
    checkOutput({tag, "_nodone1"}, 32'(done), 32'd0);
    @(posedge LSU_clk); #1;
    checkOutput({tag, "_cap_we"}, 32'(RAM_WE), 32'd0);
    checkOutput({tag, "_nodone2"}, 32'(done), 32'd0);
    @(posedge LSU_clk); #1;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_rdata"}, rdata, exp);
    @(posedge LSU_clk); #1;
  endtask

  task automatic doReject(input string tag, input logic w, input logic [2:0] f,
                          input logic [5:0] a, input logic [31:0] d, input logic [31:0] prev);
    applyStimulus(w, f, a, d);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_err"}, 32'(err), 32'd1);
    checkOutput({tag, "_we"}, 32'(RAM_WE), 32'd0);
    checkOutput({tag, "_rdata"}, rdata, prev);
    @(posedge LSU_clk); #1;
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    checkOutput({tag, "_done_off"}, 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'd0;
    LSU_rst_n = 1'b0;
    req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 6'd0; wdata = 32'd0;
    #2;
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_we", 32'(RAM_WE), 32'd0);
    checkOutput("rst_add", 32'(RAM_add), 32'd0);
    checkOutput("rst_in", 32'(RAM_in), 32'd0);
    #10 LSU_rst_n = 1'b1;
    @(posedge LSU_clk); #1;

    doStore("sw08", 3'b010, 6'h08, 32'hDEADBEEF, 4);
    doLoad("lb0b", 3'b000, 6'h0B, 32'hFFFFFFDE);
    doLoad("lbu0b", 3'b100, 6'h0B, 32'h000000DE);
    doLoad("lh0a", 3'b001, 6'h0A, 32'hFFFFDEAD);
    doLoad("lw08", 3'b010, 6'h08, 32'hDEADBEEF);
    doLoad("lhu08", 3'b101, 6'h08, 32'h0000BEEF);

    doReject("lw_bound", 1'b0, 3'b010, 6'h3E, 32'd0, 32'h0000BEEF);
    doReject("ld_f3_011", 1'b0, 3'b011, 6'h08, 32'd0, 32'h0000BEEF);
    doReject("st_f3_100", 1'b1, 3'b100, 6'h08, 32'h12345678, 32'h0000BEEF);
    doReject("sh_bound", 1'b1, 3'b001, 6'h3F, 32'h0000A5A5, 32'h0000BEEF);
    checkOutput("sh_bound_mem3f", 32'(mem[63]), 32'd0);
    checkOutput("st_f3_100_mem08", 32'(mem[8]), 32'hEF);

    doStore("sb3f", 3'b000, 6'h3F, 32'h00000080, 1);
    doLoad("lb3f", 3'b000, 6'h3F, 32'hFFFFFF80);
    doLoad("lw3c", 3'b010, 6'h3C, 32'h80000000);

    // Requests raised while busy must not disturb the store in flight.
    applyStimulus(1'b1, 3'b010, 6'h20, 32'h01020304);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 6'h30; wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req = 1'b0;
      checkOutput($sformatf("busy_add%0d", i), 32'(RAM_add), 32'h20 + 32'(i));
      checkOutput($sformatf("busy_in%0d", i), 32'(RAM_in), (32'h01020304 >> (8 * i)) & 32'hFF);
      @(posedge LSU_clk); #1;
    end
    checkOutput("busy_done", 32'(done), 32'd1);
    checkOutput("busy_err", 32'(err), 32'd0);
    @(posedge LSU_clk); #1;
    checkOutput("busy_mem30", 32'(mem[48]), 32'd0);
    checkOutput("busy_ready", 32'(ready), 32'd1);

`ifdef LSU_ALIGN_CHECK_EN
    doReject("sh05_align", 1'b1, 3'b001, 6'h05, 32'h0000ABCD, 32'h0000BEEF);
    checkOutput("sh05_mem05", 32'(mem[5]), 32'd0);
    checkOutput("sh05_mem06", 32'(mem[6]), 32'd0);
    doLoad("lw20", 3'b010, 6'h20, 32'h01020304);
`else
    doStore("sh05", 3'b001, 6'h05, 32'h0000ABCD, 2);
    doLoad("lhu05", 3'b101, 6'h05, 32'h0000ABCD);
    doLoad("lw20", 3'b010, 6'h20, 32'h01020304);
`endif

    // Reset lands after two bytes of a word store are already in RAM.
    applyStimulus(1'b1, 3'b010, 6'h10, 32'h11223344);
    @(posedge LSU_clk); #1;
    @(posedge LSU_clk); #1;
    checkOutput("midrst_pre_we", 32'(RAM_WE), 32'd1);
    #2 LSU_rst_n = 1'b0;
    #1;
    checkOutput("midrst_we", 32'(RAM_WE), 32'd0);
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_rdata", rdata, 32'd0);
    checkOutput("midrst_add", 32'(RAM_add), 32'd0);
    checkOutput("midrst_in", 32'(RAM_in), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge LSU_clk); #1;
      checkOutput($sformatf("midrst_nodone%0d", i), 32'(done), 32'd0);
    end
    #3 LSU_rst_n = 1'b1;
    @(posedge LSU_clk); #1;
    checkOutput("midrst_after_done", 32'(done), 32'd0);
    checkOutput("midrst_mem10", 32'(mem[16]), 32'h44);
    checkOutput("midrst_mem11", 32'(mem[17]), 32'h33);
    checkOutput("midrst_mem12", 32'(mem[18]), 32'h00);
    checkOutput("midrst_mem13", 32'(mem[19]), 32'h00);
    doLoad("lw10", 3'b010, 6'h10, 32'h00003344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
